// File: rtl/fx_sched_pkg.sv
// Shared types and defaults for the FX issue scheduler.
// Scoreboard destination fields are stored at a fixed maximum width so the struct is parameter-independent.
package fx_sched_pkg;

  localparam int REG_WIDTH_DEF     = 5;
  localparam int PAYLOAD_WIDTH_DEF = 256;
  localparam int FIFO_DEPTH_DEF    = 4;
  localparam int FX_LATENCY_DEF    = 2;

  // The FX unit's code in the dispatch unit-code field.
  localparam logic [2:0] FX_UNIT_CODE = 3'd0;

  // Widest GPR address the scoreboard can track; regWidth must not exceed it.
  localparam int SB_DST_WIDTH = 8;
  typedef logic [SB_DST_WIDTH-1:0] sb_dst_t;

  typedef struct packed {
    logic    valid;
    sb_dst_t dst;
  } sb_entry_t;

endpackage

// File: rtl/fx_sched_fifo.sv
// Parameterised synchronous FIFO; the count distinguishes full from empty, and pointers wrap modulo depth.
module fx_sched_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [width-1:0]       wr_data,
  output logic [width-1:0]       head_data,
  output logic [$clog2(depth):0] count
);
  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;

  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop)  rd_ptr <= rd_ptr + aw'(1);
      case ({push, pop})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fx_issue_scheduler.sv
// In-order issue scheduler for the FX unit: buffers dispatched instructions and issues one per cycle,
// stalling the head while any of its sources is still in flight in the FX pipeline.
module fx_issue_scheduler
  import fx_sched_pkg::*;
#(
  parameter int regWidth     = REG_WIDTH_DEF,
  parameter int payloadWidth = PAYLOAD_WIDTH_DEF,
  parameter int fifoDepth    = FIFO_DEPTH_DEF,
  parameter int fxLatency    = FX_LATENCY_DEF
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic                      instrValid_i,
  output logic                      instrReady_o,
  input  logic [payloadWidth-1:0]   instrPayload_i,
  input  logic                      src1Used_i,
  input  logic                      src2Used_i,
  input  logic [regWidth-1:0]       src1Reg_i,
  input  logic [regWidth-1:0]       src2Reg_i,
  input  logic                      dstWrite_i,
  input  logic [regWidth-1:0]       dstReg_i,
  output logic                      issueEnable_o,
  output logic [payloadWidth-1:0]   issuePayload_o,
  output logic [$clog2(fifoDepth):0] occupancy_o
);
  // Handshake: an instruction is accepted on a rising edge where instrValid_i && instrReady_o.
  // instrReady_o depends only on the registered count and flush_i, never on instrValid_i.

  typedef struct packed {
    logic [payloadWidth-1:0] payload;
    logic                    src1_used;
    logic [regWidth-1:0]     src1_reg;
    logic                    src2_used;
    logic [regWidth-1:0]     src2_reg;
    logic                    dst_write;
    logic [regWidth-1:0]     dst_reg;
  } entry_t;

  entry_t                    enq_entry;
  entry_t                    head;
  logic [$clog2(fifoDepth):0] count;
  logic                      push;
  logic                      pop;
  logic                      blocked;
  sb_entry_t [fxLatency-1:0] sb_q;

  assign enq_entry = '{payload:   instrPayload_i,
                       src1_used: src1Used_i, src1_reg: src1Reg_i,
                       src2_used: src2Used_i, src2_reg: src2Reg_i,
                       dst_write: dstWrite_i, dst_reg:  dstReg_i};

  assign instrReady_o = (count < ($clog2(fifoDepth)+1)'(fifoDepth)) && !flush_i;
  assign push         = instrValid_i && instrReady_o;
  assign occupancy_o  = count;

  fx_sched_fifo #(
    .width ($bits(entry_t)),
    .depth (fifoDepth)
  ) u_fifo (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .flush     (flush_i),
    .push      (push),
    .pop       (pop),
    .wr_data   (enq_entry),
    .head_data (head),
    .count     (count)
  );

  always_comb begin
    blocked = 1'b0;
    for (int i = 0; i < fxLatency; i++) begin
      if (sb_q[i].valid && head.src1_used && sb_q[i].dst == sb_dst_t'(head.src1_reg)) blocked = 1'b1;
      if (sb_q[i].valid && head.src2_used && sb_q[i].dst == sb_dst_t'(head.src2_reg)) blocked = 1'b1;
    end
  end

  assign pop = (count != '0) && !blocked && !flush_i;

  // Stage i holds the destination of the instruction issued i+1 edges ago; flush leaves it intact.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sb_q <= '0;
    end else begin
      sb_q[0] <= '{valid: pop && head.dst_write, dst: sb_dst_t'(head.dst_reg)};
      for (int i = 1; i < fxLatency; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      issueEnable_o  <= 1'b0;
      issuePayload_o <= '0;
    end else begin
      issueEnable_o <= pop;
      if (pop) issuePayload_o <= head.payload;
    end
  end

endmodule

// File: tb/tb_fx_issue_scheduler.sv
// Randomised bench for fx_issue_scheduler against a queue model that tracks, per register,
// the earliest cycle a reader of it may issue.
module tb_fx_issue_scheduler;
  localparam int RW    = 5;
  localparam int PW    = 256;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock_i = 1'b0;
  logic          reset_i, flush_i, instrValid_i, instrReady_o;
  logic [PW-1:0] instrPayload_i;
  logic          src1Used_i, src2Used_i, dstWrite_i;
  logic [RW-1:0] src1Reg_i, src2Reg_i, dstReg_i;
  logic          issueEnable_o;
  logic [PW-1:0] issuePayload_o;
  logic [CW-1:0] occupancy_o;

  always #5 clock_i = ~clock_i;

  fx_issue_scheduler #(
    .regWidth(RW), .payloadWidth(PW), .fifoDepth(DEPTH), .fxLatency(LAT)
  ) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .flush_i        (flush_i),
    .instrValid_i   (instrValid_i),
    .instrReady_o   (instrReady_o),
    .instrPayload_i (instrPayload_i),
    .src1Used_i     (src1Used_i),
    .src2Used_i     (src2Used_i),
    .src1Reg_i      (src1Reg_i),
    .src2Reg_i      (src2Reg_i),
    .dstWrite_i     (dstWrite_i),
    .dstReg_i       (dstReg_i),
    .issueEnable_o  (issueEnable_o),
    .issuePayload_o (issuePayload_o),
    .occupancy_o    (occupancy_o)
  );

  typedef struct packed {
    logic [PW-1:0] pl;
    logic          s1u;
    logic [RW-1:0] s1r;
    logic          s2u;
    logic [RW-1:0] s2r;
    logic          dw;
    logic [RW-1:0] dr;
  } instr_t;

  // Reference model state
  instr_t        mq[$];
  int            ready_cyc[32];
  int            cyc;
  logic          m_en;
  logic [PW-1:0] m_pl;
  logic [PW-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic instr_t mk_instr(input logic s1u, input int s1r, input logic s2u, input int s2r,
                                      input logic dw, input int dr);
    instr_t t;
    for (int w = 0; w < PW / 32; w++) t.pl[w*32 +: 32] = $urandom;
    t.s1u = s1u; t.s1r = RW'(s1r);
    t.s2u = s2u; t.s2r = RW'(s2r);
    t.dw  = dw;  t.dr  = RW'(dr);
    return t;
  endfunction

  function automatic instr_t rand_instr(input int max_reg);
    return mk_instr(1'($urandom_range(0, 1)), $urandom_range(0, max_reg),
                    1'($urandom_range(0, 1)), $urandom_range(0, max_reg),
                    1'($urandom_range(0, 3) != 0), $urandom_range(0, max_reg));
  endfunction

  function automatic bit srcs_ready(input instr_t t, input int issue_cyc);
    if (t.s1u && issue_cyc < ready_cyc[t.s1r]) return 1'b0;
    if (t.s2u && issue_cyc < ready_cyc[t.s2r]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock cycle: drive inputs, check pre-edge outputs, advance model and DUT, check post-edge outputs.
  task automatic cycle_step(input instr_t ins, input logic v, input logic fl, input logic rst);
    bit     m_ready, m_push, m_pop;
    instr_t h;
    instrValid_i   = v;
    flush_i        = fl;
    reset_i        = rst;
    instrPayload_i = ins.pl;
    src1Used_i     = ins.s1u; src1Reg_i = ins.s1r;
    src2Used_i     = ins.s2u; src2Reg_i = ins.s2r;
    dstWrite_i     = ins.dw;  dstReg_i  = ins.dr;
    #1;
    m_ready = (mq.size() < DEPTH) && !fl;
    check("instr_ready", PW'(instrReady_o), PW'(m_ready));
    check("occupancy", PW'(occupancy_o), PW'(mq.size()));
    m_pop  = (mq.size() > 0) && !fl && srcs_ready(mq[0], cyc + 1);
    m_push = v && m_ready;

    @(posedge clock_i);
    cyc++;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      foreach (ready_cyc[i]) ready_cyc[i] = 0;
      m_en = 1'b0;
      m_pl = '0;
    end else begin
      if (fl) mq.delete();
      m_en = m_pop;
      if (m_pop) begin
        h    = mq.pop_front();
        m_pl = h.pl;
        exp_q.push_back(h.pl);
        if (h.dw) ready_cyc[h.dr] = cyc + LAT + 1;
      end
      if (m_push) mq.push_back(ins);
    end

    #1;
    check("issue_enable", PW'(issueEnable_o), PW'(m_en));
    check("issue_payload", issuePayload_o, m_pl);
    if (issueEnable_o === 1'b1) begin
      if (exp_q.size() == 0) check("issue_extra", PW'(issueEnable_o), PW'(0));
      else                   check("issue_order", issuePayload_o, exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_step(mk_instr(0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    instr_t t;
    int     vp, fp, rp;

    // Clock/reset
    cyc = 0;
    t = mk_instr(0, 0, 0, 0, 0, 0);
    instrValid_i = 0; flush_i = 0; reset_i = 1;
    instrPayload_i = '0; src1Used_i = 0; src2Used_i = 0;
    src1Reg_i = '0; src2Reg_i = '0; dstWrite_i = 0; dstReg_i = '0;
    repeat (2) @(posedge clock_i);
    #1;
    reset_i = 0;
    mq.delete(); exp_q.delete();
    foreach (ready_cyc[i]) ready_cyc[i] = 0;
    m_en = 0; m_pl = '0;
    #1;
    check("reset_enable", PW'(issueEnable_o), PW'(0));
    check("reset_payload", issuePayload_o, PW'(0));
    check("reset_occupancy", PW'(occupancy_o), PW'(0));
    check("reset_ready", PW'(instrReady_o), PW'(1));

    // Four independent instructions writing r1..r4
    for (int i = 1; i <= 4; i++) cycle_step(mk_instr(0, 0, 0, 0, 1, i), 1'b1, 1'b0, 1'b0);
    idle(3);

    // Producer r5, dependent consumer, independent follower
    cycle_step(mk_instr(0, 0, 0, 0, 1, 5), 1'b1, 1'b0, 1'b0);
    cycle_step(mk_instr(1, 5, 0, 0, 1, 6), 1'b1, 1'b0, 1'b0);
    cycle_step(mk_instr(0, 0, 1, 9, 1, 10), 1'b1, 1'b0, 1'b0);
    idle(6);

    // Dependency chain fills the FIFO; extra offers are refused while full
    for (int i = 0; i < 8; i++) cycle_step(mk_instr(1, 11, 0, 0, 1, 11), 1'b1, 1'b0, 1'b0);
    idle(20);

    // Producer r7 issues, then flush with entries buffered; new reader of r7 must still wait
    cycle_step(mk_instr(0, 0, 0, 0, 1, 7), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle_step(mk_instr(1, 7, 0, 0, 1, 12), 1'b1, 1'b0, 1'b0);
    cycle_step(mk_instr(1, 7, 0, 0, 0, 0), 1'b1, 1'b1, 1'b0);
    cycle_step(mk_instr(1, 7, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    idle(6);

    // Reset with buffered entries and live scoreboard; reader of prior dst issues immediately after
    cycle_step(mk_instr(0, 0, 0, 0, 1, 8), 1'b1, 1'b0, 1'b0);
    cycle_step(mk_instr(1, 8, 0, 0, 1, 8), 1'b1, 1'b0, 1'b0);
    cycle_step(mk_instr(1, 8, 0, 0, 1, 8), 1'b1, 1'b0, 1'b0);
    cycle_step(mk_instr(0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b1);
    cycle_step(mk_instr(1, 8, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    idle(4);

    // Randomised phases with varying pressure, flush and reset rates
    for (int phase = 0; phase < 8; phase++) begin
      vp = (phase % 4 == 0) ? 40 : 90;
      fp = (phase % 2 == 0) ? 0 : 4;
      rp = (phase == 5) ? 2 : 0;
      for (int i = 0; i < 500; i++) begin
        t = rand_instr((phase < 4) ? 3 : 15);
        cycle_step(t, 1'($urandom_range(0, 99) < vp), 1'($urandom_range(0, 99) < fp),
                   1'($urandom_range(0, 99) < rp));
      end
    end
    idle(12);
    check("drain_occupancy", PW'(occupancy_o), PW'(0));
    check("drain_exp_q", PW'(exp_q.size()), PW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fx_issue_scheduler.md
# fx_issue_scheduler

In-order issue scheduler in front of the fixed-point unit (FXUnit). Accepts decoded FX-bound instructions from dispatch through a valid/ready handshake and buffers them in a small FIFO. Issues at most one per cycle to the FX unit, stalling the head while any source register is still being produced by an in-flight FX instruction (no bypass network). Drives the FX unit's enable and instruction payload, and exposes occupancy for dispatch throttling.

## Interface
Parameters:
- regWidth, 5, GPR address width
- payloadWidth, 256, opaque instruction bundle forwarded unchanged to FXUnit (operands, imm, opcodes, format, unit code)
- fifoDepth, 4, buffer entries; power of two, ≥2
- fxLatency, 2, cycles from issue until the FX result is written to the register file

Ports:
- clock_i  in  1  rising-edge clock
- reset_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all buffered, not-yet-issued instructions
- instrValid_i  in  1  dispatch offers an instruction
- instrReady_o  out  1  scheduler can accept this cycle
- instrPayload_i  in  payloadWidth  instruction bundle
- src1Used_i, src2Used_i  in  1 each  source register is read
- src1Reg_i, src2Reg_i  in  regWidth each  source addresses
- dstWrite_i  in  1  instruction writes a GPR
- dstReg_i  in  regWidth  destination address
- issueEnable_o  out  1  to FXUnit enable_i
- issuePayload_o  out  payloadWidth  to FXUnit inputs
- occupancy_o  out  log2(fifoDepth)+1  buffered entry count

## Operation
- Enqueue on edge where instrValid_i && instrReady_o; payload, source/destination fields stored together.
- instrReady_o = (count < fifoDepth) && !flush_i; full FIFO refuses enqueue even if a pop occurs the same cycle.
- Scoreboard: fxLatency-stage shift register of {valid, dst}. Stage 0 loads {issued && dstWrite, dstReg} on each issue edge, else {0, x}; all stages shift every cycle.
- Hazard: head blocked if any used source equals the dst of a valid scoreboard stage.
- Issue: head present, not blocked, no flush → pop; register issueEnable_o=1 and issuePayload_o=head payload. Otherwise issueEnable_o=0 and issuePayload_o holds its last value.
- Strictly in order; a blocked head blocks all younger entries.
- Flush: FIFO emptied, issueEnable_o=0 next cycle, any enqueue that cycle dropped; scoreboard kept (issued instructions still complete).
- Enqueue + issue in the same cycle: count unchanged.
- Pointers wrap modulo fifoDepth; count distinguishes full from empty.

## Timing
- Reset values: issueEnable_o=0, issuePayload_o=0, occupancy_o=0, instrReady_o=1 (after reset deasserts), pointers and scoreboard valid bits 0.
- Reset mid-operation discards buffered and in-flight state at that edge.
- Enqueue-to-issue latency: instruction accepted at edge k has issueEnable_o high after edge k+1 at the earliest.
- Dependent spacing: if producer has issueEnable_o high in cycle c, a consumer reading its dst has issueEnable_o high no earlier than cycle c+fxLatency+1.
- Independent back-to-back instructions issue on consecutive cycles.
- occupancy_o and instrReady_o reflect registered count; no combinational path from instrValid_i to instrReady_o.

## Structure
- Package fx_sched_pkg: scoreboard entry struct {valid, dst}, FX unit code constant (0), default parameter values.
- Sub-module fx_sched_fifo: parameterised synchronous FIFO (push, pop, flush, count, head data); hazard check and scoreboard stay in the top.

## Test plan
- Reset then 4 independent enqueues (dst r1..r4) → issueEnable_o high four consecutive cycles starting one cycle after first accept; occupancy returns to 0.
- Producer writes r5, next consumer reads r5 (fxLatency=2) → consumer issues exactly 3 cycles after producer; an intervening independent instruction behind it waits too.
- Fill FIFO with 4 entries while head blocked → instrReady_o=0, 5th valid ignored; on unblock, instrReady_o returns 1 one cycle after first pop.
- Enqueue and pop simultaneously at occupancy 2 → occupancy stays 2; write pointer wraps past index 3 correctly.
- flush_i with 3 buffered and one just issued (dst r7) → occupancy 0 next cycle, no further issue; newly enqueued reader of r7 still stalls for the remaining scoreboard window.
- reset_i asserted with 2 buffered and scoreboard valid → next cycle issueEnable_o=0, occupancy 0, reader of prior dst issues without stall.
